// File: rtl/ultrasonido_multicanal.sv
// Multi-channel trigger/echo ultrasonic ranger controller with a 1 us tick prescaler.
// It sweeps the enabled channels in ascending order and reports each echo width in ticks, or a timeout.
module ultrasonido_multicanal #(
   parameter int unsigned N_CH       = 4,
   parameter int unsigned TICK_DIV   = 50,
   parameter int unsigned TRIG_US    = 10,
   parameter int unsigned TIMEOUT_US = 30000,
   parameter int unsigned HOLDOFF_US = 60000,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       orden,
   input  logic                                       continuo,
   input  logic [N_CH-1:0]                            ch_mask,
   input  logic [N_CH-1:0]                            echo,
   output logic [N_CH-1:0]                            trigger,
   output logic                                       ENABLE,
   output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_id,
   output logic [CNT_W-1:0]                           dist_us,
   output logic                                       valid,
   output logic                                       timeout
);

   localparam int unsigned      CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned      PRE_W     = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] TRIG_C    = CNT_W'(TRIG_US);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_US);
   localparam logic [CNT_W-1:0] HOLDOFF_C = CNT_W'(HOLDOFF_US);

   typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF} state_t;

   state_t           state_q, state_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] w_q, w_d;
   logic [CNT_W-1:0] dist_q, dist_d;
   logic [N_CH-1:0]  sync1_q, sync1_d;
   logic [N_CH-1:0]  sync2_q, sync2_d;
   logic [N_CH-1:0]  hist_q, hist_d;
   logic [N_CH-1:0]  trigger_q, trigger_d;
   logic [CH_W-1:0]  ch_q, ch_d;
   logic             enable_q, enable_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;

   logic             tick, rise, fall;
   logic [CNT_W-1:0] t_inc, w_inc;
   logic             low_found, above_found;
   logic [CH_W-1:0]  low_idx, above_idx;

   always_comb begin
      low_found   = 1'b0;
      low_idx     = '0;
      above_found = 1'b0;
      above_idx   = '0;
      // Descending scan so the last hit is the lowest qualifying index.
      for (int unsigned i = N_CH; i > 0; i--) begin
         if (ch_mask[i-1]) begin
            low_found = 1'b1;
            low_idx   = CH_W'(i - 1);
            if ((i - 1) > 32'(ch_q)) begin
               above_found = 1'b1;
               above_idx   = CH_W'(i - 1);
            end
         end
      end
   end

   always_comb begin
      tick  = (pre_q == PRE_LAST);
      t_inc = (tick && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
      w_inc = (tick && (w_q != '1)) ? w_q + 1'b1 : w_q;
      rise  = sync2_q[ch_q] & ~hist_q[ch_q];
      fall  = ~sync2_q[ch_q] & hist_q[ch_q];

      state_d   = state_q;
      pre_d     = tick ? '0 : pre_q + 1'b1;
      cnt_d     = cnt_q;
      w_d       = w_q;
      dist_d    = dist_q;
      sync1_d   = echo;
      sync2_d   = sync1_q;
      hist_d    = sync2_q;
      trigger_d = trigger_q;
      ch_d      = ch_q;
      valid_d   = 1'b0;
      timeout_d = timeout_q;

      unique case (state_q)
         IDLE: begin
            if (orden && low_found) begin
               state_d            = TRIG;
               ch_d               = low_idx;
               trigger_d          = '0;
               trigger_d[low_idx] = 1'b1;
               pre_d              = '0;
               cnt_d              = '0;
            end
         end
         TRIG: begin
            cnt_d = t_inc;
            if (t_inc >= TRIG_C) begin
               state_d   = WAIT_ECHO;
               trigger_d = '0;
               pre_d     = '0;
               cnt_d     = '0;
            end
         end
         WAIT_ECHO: begin
            cnt_d = t_inc;
            if (t_inc >= TIMEOUT_C) begin
               state_d   = HOLDOFF;
               dist_d    = '0;
               timeout_d = 1'b1;
               valid_d   = 1'b1;
               pre_d     = '0;
               cnt_d     = '0;
            end else if (rise) begin
               state_d = MEASURE;
               pre_d   = '0;
               w_d     = '0;
            end
         end
         MEASURE: begin
            cnt_d = t_inc;
            w_d   = w_inc;
            if (fall || (t_inc >= TIMEOUT_C)) begin
               state_d   = HOLDOFF;
               dist_d    = fall ? w_inc : '0;
               timeout_d = ~fall;
               valid_d   = 1'b1;
               pre_d     = '0;
               cnt_d     = '0;
            end
         end
         HOLDOFF: begin
            cnt_d = t_inc;
            if (t_inc >= HOLDOFF_C) begin
               pre_d = '0;
               cnt_d = '0;
               if (above_found || (continuo && low_found)) begin
                  state_d            = TRIG;
                  ch_d               = above_found ? above_idx : low_idx;
                  trigger_d          = '0;
                  trigger_d[ch_d]    = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      enable_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         pre_q     <= '0;
         cnt_q     <= '0;
         w_q       <= '0;
         dist_q    <= '0;
         sync1_q   <= '0;
         sync2_q   <= '0;
         hist_q    <= '0;
         trigger_q <= '0;
         ch_q      <= '0;
         enable_q  <= 1'b0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         cnt_q     <= cnt_d;
         w_q       <= w_d;
         dist_q    <= dist_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         hist_q    <= hist_d;
         trigger_q <= trigger_d;
         ch_q      <= ch_d;
         enable_q  <= enable_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   assign trigger = trigger_q;
   assign ENABLE  = enable_q;
   assign ch_id   = ch_q;
   assign dist_us = dist_q;
   assign valid   = valid_q;
   assign timeout = timeout_q;

endmodule

// File: doc/ultrasonido_multicanal.md
Name: ultrasonido_multicanal

Overview:
Parametrised controller for N ultrasonic rangers (trigger/echo type). It generates the trigger pulse and times the echo width in microseconds, with timeout and an inter-shot holdoff. Channels are swept in ascending index order over an enable mask, either as one sweep per `orden` pulse or continuously. It replaces the fixed single-channel ultrasonido state machine plus its divider, with the divider integrated as a 1 us tick prescaler.

Parameters:
N_CH, 4, number of sensor channels (1..16)
TICK_DIV, 50, clk cycles per 1 us tick (>=2)
TRIG_US, 10, trigger pulse width in ticks
TIMEOUT_US, 30000, max ticks from entering WAIT_ECHO to echo falling edge
HOLDOFF_US, 60000, ticks of quiet time after each channel before the next trigger
CNT_W, 16, width of tick counter and dist_us (must hold max(TIMEOUT_US, HOLDOFF_US))

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
orden  in  1  start request, sampled high for >=1 clk
continuo  in  1  1 = repeat sweeps until cleared; 0 = single sweep
ch_mask  in  N_CH  channel enables, sampled at each channel selection
echo  in  N_CH  raw echo inputs (asynchronous)
trigger  out  N_CH  trigger outputs, one-hot or zero
ENABLE  out  1  busy: high whenever state != IDLE
ch_id  out  clog2(N_CH) (min 1)  channel of current or last result
dist_us  out  CNT_W  echo high width in ticks
valid  out  1  one-clk result strobe
timeout  out  1  qualifies valid: 1 = no/overlong echo, dist_us = 0

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream): state IDLE; trigger=0, ENABLE=0, ch_id=0, dist_us=0, valid=0, timeout=0; synchronisers, prescaler and counters cleared.
- Echo path: 2-FF synchroniser per channel plus one history register; edges are detected on the synchronised value. Latency is 2 clk from pin to synchronised value.
- Prescaler: counts 0..TICK_DIV-1 and is cleared on every state entry. The tick fires when it wraps, so state durations are exact multiples of TICK_DIV clk.
- IDLE:
  - orden=1 and ch_mask!=0: select the lowest set mask bit and go to TRIG.
  - orden=1 with ch_mask=0: ignored.
- TRIG: trigger[ch]=1 for exactly TRIG_US ticks, then go to WAIT_ECHO.
- WAIT_ECHO: tick counter t starts at 0.
  - Synchronised rising edge on echo[ch]: go to MEASURE, with the width counter w cleared.
  - Echo already high at entry: this is not a rising edge, so it is treated as stuck high.
- MEASURE: w increments each tick, and t continues to increment.
  - Falling edge: dist_us=w, timeout=0, valid=1 for 1 clk, go to HOLDOFF.
- Timeout: t reaching TIMEOUT_US in WAIT_ECHO or MEASURE produces dist_us=0, timeout=1, valid=1, then HOLDOFF.
  - If a falling edge and the timeout occur on the same clk, the edge wins.
- HOLDOFF: lasts HOLDOFF_US ticks, then advances to the next set mask bit above ch (using the current ch_mask) and goes to TRIG.
  - If no higher bit is set, the sweep ends.
    - continuo=1 and ch_mask!=0: wrap to the lowest set bit and go to TRIG.
    - Otherwise: go to IDLE.
- ch_id updates on entry to TRIG. dist_us and timeout hold their values until the next valid.
- orden is ignored while ENABLE=1. Clearing continuo mid-sweep finishes the current sweep.
- Clearing ch_mask mid-sweep: the current channel completes, then the block goes to IDLE.
- Counters saturate and never wrap. A result always precedes the move to the next channel.

Test Plan:
Common setup: N_CH=2, TICK_DIV=4, TRIG_US=10, TIMEOUT_US=100, HOLDOFF_US=20, CNT_W=8.
1. Single shot: ch_mask=01, orden pulse; echo[0] rises 5 ticks after trigger falls and stays high 37 ticks -> trigger[0] high exactly 40 clk; valid with ch_id=0, dist_us=37 (+/-1 tick for synchroniser alignment), timeout=0; after holdoff, ENABLE=0.
2. No echo: ch_mask=01, echo held 0 -> valid 100 ticks after WAIT_ECHO entry with timeout=1, dist_us=0.
3. Stuck-high echo, and echo high past TIMEOUT -> both give timeout=1, dist_us=0; trigger never asserted again before the 20-tick holdoff expires.
4. Sweep/continuous: ch_mask=11, continuo=1 -> results alternate ch_id 0,1,0,1 with trigger one-hot. Clear continuo during ch0 -> ch1 completes, then IDLE.
5. Ignored requests: orden while ENABLE=1 -> no extra shot. orden with ch_mask=00 -> ENABLE stays 0.
6. Reset mid-MEASURE (reset=0 for 1 clk) -> all outputs immediately at reset values; no valid emitted; a new orden works normally.
